// File: rtl/timer_rx_pkg.sv
// Shared definitions for the countdown-timer serial receiver.
//   - default payload width and largest legal countdown value
//   - frame deserializer and lamp state enumerations
//   - one-hot lamp encodings {red, yellow, green} and a state-to-lamp helper
package timer_rx_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MAX_VAL_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } frame_state_t;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } lamp_state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    function automatic logic [2:0] lamp_light(input lamp_state_t s);
        case (s)
            GREEN:   return LIGHT_GREEN;
            YELLOW:  return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

endpackage

// File: rtl/timer_rx_lamp.sv
// Traffic-lamp sequencer driven by accepted countdown values.
//   clk, rst   : system clock, synchronous active-high reset
//   count_vld  : one-cycle pulse, count_val was just updated
//   count_val  : accepted countdown value
//   light      : one-hot {red, yellow, green}
// Each accepted value of zero advances RED -> GREEN -> YELLOW -> RED; the
// lamp changes on the cycle after the count_vld pulse.
module timer_rx_lamp
    import timer_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       count_vld,
    input  logic [3:0] count_val,
    output logic [2:0] light
);

    lamp_state_t state, state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RED;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (count_vld && (count_val == 4'd0)) begin
            case (state)
                RED:     state_n = GREEN;
                GREEN:   state_n = YELLOW;
                default: state_n = RED;
            endcase
        end
    end

    assign light = lamp_light(state);

endmodule

// File: rtl/timer_rx.sv
// Serial receiver for countdown values sent by a remote timer.
//   clk, rst   : system clock, synchronous active-high reset
//   ser_in     : serial payload bit, LSB first
//   ser_we     : frame strobe
//   count_val  : last accepted countdown value (reset: MAX_VAL)
//   count_vld  : one-cycle pulse, count_val updated this cycle
//   frame_err  : one-cycle pulse, frame aborted by an early ser_we drop
//   range_err  : one-cycle pulse, complete frame carried payload > MAX_VAL
//   light      : one-hot lamp drive {red, yellow, green}
//   state_dbg  : current deserializer state (frame_state_t encoding)
//
// Framing protocol: a frame starts on a rising edge of ser_we (ser_we must
// have been sampled low on the previous cycle). That first high cycle is the
// lead cycle and its ser_in is discarded. The following DATA_W high cycles
// carry payload bits 0..DATA_W-1; the FSM sits in LEAD for the first of them
// (confirming the strobe stayed up) and in DATA for the rest. ser_we falling
// before the last bit aborts the frame. Once complete, the FSM waits in DONE
// for ser_we to drop, ignoring any extra high cycles. DATA_W must be >= 4.
module timer_rx
    import timer_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_VAL = MAX_VAL_DEF
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_in,
    input  logic       ser_we,
    output logic [3:0] count_val,
    output logic       count_vld,
    output logic       frame_err,
    output logic       range_err,
    output logic [2:0] light,
    output logic [1:0] state_dbg
);

    localparam int                 CNT_W       = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]  MAX_PAYLOAD = DATA_W'(MAX_VAL);
    localparam logic [3:0]         RST_VAL     = 4'(MAX_VAL);

    frame_state_t        state, state_n;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   shift_reg, shift_n;
    logic [3:0]          count_val_n;
    logic                vld_n, ferr_n, rerr_n;
    // Previous ser_we sample; reset high so a strobe already up when reset
    // releases is not mistaken for a new frame.
    logic                we_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            count_val <= RST_VAL;
            count_vld <= 1'b0;
            frame_err <= 1'b0;
            range_err <= 1'b0;
            we_prev   <= 1'b1;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            count_val <= count_val_n;
            count_vld <= vld_n;
            frame_err <= ferr_n;
            range_err <= rerr_n;
            we_prev   <= ser_we;
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        count_val_n = count_val;
        vld_n       = 1'b0;
        ferr_n      = 1'b0;
        rerr_n      = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_n = '0;
                shift_n   = '0;
                if (ser_we && !we_prev) begin
                    state_n = LEAD;
                end
            end

            LEAD, DATA: begin
                if (!ser_we) begin
                    // Early drop: partial payload is thrown away.
                    state_n   = IDLE;
                    ferr_n    = 1'b1;
                    bit_cnt_n = '0;
                    shift_n   = '0;
                end else begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt == CNT_W'(i)) begin
                            shift_n[i] = ser_in;
                        end
                    end
                    if (bit_cnt == LAST_BIT) begin
                        // Last bit captured: result is registered so the
                        // pulse lands on the first DONE cycle.
                        state_n = DONE;
                        if (shift_n > MAX_PAYLOAD) begin
                            rerr_n = 1'b1;
                        end else begin
                            count_val_n = shift_n[3:0];
                            vld_n       = 1'b1;
                        end
                    end else begin
                        state_n   = DATA;
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            DONE: begin
                if (!ser_we) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    assign state_dbg = state;

    timer_rx_lamp u_lamp (
        .clk       (clk),
        .rst       (rst),
        .count_vld (count_vld),
        .count_val (count_val),
        .light     (light)
    );

endmodule

// File: doc/timer_rx.md
TIMER_RX -- requirements
Module: timer_rx

Interface
REQ-001 Parameter DATA_W, default 8, meaning serial payload width in bits.
REQ-002 Parameter MAX_VAL, default 9, meaning largest legal countdown value.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ser_in  input  1  serial data bit from the countdown timer, LSB first.
REQ-006 ser_we  input  1  frame strobe; high for exactly 1 lead cycle plus DATA_W data cycles.
REQ-007 count_val  output  4  last accepted countdown value.
REQ-008 count_vld  output  1  one-cycle pulse: count_val updated this cycle.
REQ-009 frame_err  output  1  one-cycle pulse: frame aborted (ser_we fell early).
REQ-010 range_err  output  1  one-cycle pulse: complete frame with payload > MAX_VAL.
REQ-011 light  output  3  one-hot lamp drive {red, yellow, green}, bit 2 = red.

Function
REQ-012 FSM states SHALL be IDLE, LEAD, DATA, DONE.
REQ-013 IDLE -> LEAD SHALL occur on the first cycle ser_we is sampled high; ser_in ignored in LEAD.
REQ-014 LEAD -> DATA SHALL occur on the next cycle if ser_we is still high, else -> IDLE with frame_err pulse.
REQ-015 In DATA, each cycle with ser_we high SHALL shift ser_in into shift register bit position bit_cnt (bit_cnt 0..DATA_W-1, LSB first).
REQ-016 DATA SHALL exit to DONE on the cycle after bit DATA_W-1 is captured.
REQ-017 ser_we sampled low in DATA before DATA_W bits are captured SHALL cause frame_err pulse, discard partial data, -> IDLE; count_val unchanged.
REQ-018 On entering DONE with payload <= MAX_VAL: count_val <= payload[3:0], count_vld pulse the same cycle count_val changes.
REQ-019 On entering DONE with payload > MAX_VAL: range_err pulse, count_val unchanged, no count_vld.
REQ-020 Latency: count_vld SHALL assert 1 cycle after the cycle that captures bit DATA_W-1.
REQ-021 DONE SHALL hold until ser_we is sampled low, then -> IDLE; bits while ser_we stays high in DONE ignored, no error.
REQ-022 A new frame SHALL require at least one cycle of ser_we low between frames.
REQ-023 Lamp FSM states RED, GREEN, YELLOW; light = 3'b100, 3'b001, 3'b010 respectively.
REQ-024 Lamp FSM SHALL advance RED->GREEN->YELLOW->RED on each count_vld with count_val == 0, same cycle lamp changes one cycle after count_vld.
REQ-025 Accepted non-zero values and error frames SHALL NOT change light.
REQ-026 bit_cnt SHALL be $clog2(DATA_W)+1 bits wide; no wrap-around permitted inside a frame.
REQ-027 Pulse outputs SHALL be mutually exclusive in any cycle.

Reset
REQ-028 rst high SHALL force: frame FSM IDLE, lamp FSM RED, light 3'b100, count_val = MAX_VAL[3:0], count_vld/frame_err/range_err 0, shift register and bit_cnt 0.
REQ-029 rst asserted mid-frame SHALL discard the frame without error pulse; after rst release a frame is recognised only after ser_we is seen low then high.
REQ-030 rst SHALL override every other input in the same cycle.

Structure
REQ-031 Shared package SHALL hold frame-state and lamp-state enumerations, lamp encodings, and default DATA_W/MAX_VAL constants.
REQ-032 One sub-module, timer_rx_lamp (lamp FSM: inputs count_vld, count_val; output light), SHALL be instantiated; deserializer stays in timer_rx.

Verification
REQ-033 Frame: ser_we high 9 cycles, data bits 1,0,0,1,0,0,0,0 -> count_val=9, one count_vld pulse 1 cycle after last bit, light stays 3'b100.
REQ-034 Countdown 9..0 over ten frames separated by 52 low cycles -> ten count_vld pulses; on value 0, light 3'b100 -> 3'b001 next cycle; two more full countdowns -> 3'b010 then 3'b100.
REQ-035 ser_we drops after lead + 4 data cycles -> single frame_err pulse, count_val unchanged, next well-formed frame value 5 accepted.
REQ-036 Payload 8'd12 -> range_err pulse, no count_vld, count_val unchanged.
REQ-037 ser_we held high 14 cycles with payload 3 -> exactly one count_vld, count_val=3, no error; next frame accepted only after ser_we low.
REQ-038 rst pulsed during data cycle 3 of a frame -> outputs at reset values, no pulses; ser_we still high after release -> ignored until low then high.
